drbg_generate: RTL and testbench
================================

# drbg_generate

CTR_DRBG generate stage. Takes working state (Key, V) after instantiate/reseed and produces a requested number of 128-bit pseudorandom blocks using an external AES-256 engine. After producing the blocks it runs the mandatory backtracking-resistance update through the downstream update stage. It also tracks the reseed counter. It sits between the DRBG control FSM and the update stage: it feeds the update stage its `provided_data` and start trigger, and consumes its completion.

## Interface
- `MAX_BLOCKS`, 16: maximum 128-bit blocks per request.
- `RESEED_LIMIT`, 1024: maximum requests between reseeds.
- `RC_W`, 32: reseed counter width; must satisfy RESEED_LIMIT < 2^RC_W.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `num_blocks` in $clog2(MAX_BLOCKS+1): number of blocks requested.
- `key_in` in 256: working Key, latched on accepted start.
- `v_in` in 128: working V, latched on accepted start.
- `reseed_load` in 1: sets the reseed counter to 1; honoured only in IDLE.
- `aes_req` out 1: encryption request.
- `aes_key` out 256: latched Key.
- `aes_pt` out 128: plaintext, which is the current V.
- `aes_ack` in 1: one-cycle pulse with a valid `aes_ct`.
- `aes_ct` in 128: ciphertext.
- `out_valid` out 1: output block valid.
- `out_data` out 128: pseudorandom block.
- `out_ready` in 1: consumer accepts the block.
- `upd_start` out 1: one-cycle pulse that starts the update stage.
- `upd_data` out 384: `provided_data` for the update stage.
- `v_out` out 128: final V, handed to the update stage.
- `upd_done` in 1: update stage finished.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; 1 means the request was rejected.
- `reseed_required` out 1: level output; counter > RESEED_LIMIT.

## Operation
- States: IDLE, CHECK, ENC_REQ, ENC_WAIT, EMIT, UPD, UPD_WAIT, FIN.
- IDLE + `start`:
  - Latch `key_in`, `v_in`, `num_blocks` into K, V, N.
  - Clear the block counter.
  - Go to CHECK.
- CHECK:
  - If `reseed_required` or N > MAX_BLOCKS: set `err`=1 and go to FIN. No AES traffic, no update, counter unchanged.
  - Else if N=0: go to UPD.
  - Else: go to ENC_REQ.
- ENC_REQ:
  - V <= V+1, modulo 2^128.
  - Next cycle, assert `aes_req` with `aes_pt`=V and go to ENC_WAIT.
- ENC_WAIT:
  - Hold `aes_req` and `aes_pt` stable until `aes_ack`.
  - On `aes_ack`: capture `aes_ct` into `out_data` and go to EMIT.
- EMIT:
  - Hold `out_valid` and `out_data` until `out_ready`.
  - On handshake, increment the block counter.
  - If counter = N, go to UPD; else go to ENC_REQ.
- UPD:
  - Pulse `upd_start`.
  - `v_out` = V, held stable through UPD_WAIT.
  - Go to UPD_WAIT.
- UPD_WAIT: wait for `upd_done`, then go to FIN.
- FIN:
  - Pulse `done`.
  - If `err`=0, increment the reseed counter, saturating at all-ones.
  - Return to IDLE.
- `reseed_required` = (counter > RESEED_LIMIT).
- `reseed_load` in IDLE sets the counter to 1. If it coincides with `start`, `reseed_load` is applied first, then `start` is accepted.
- `start` is ignored outside IDLE. `reseed_load` is ignored outside IDLE.
- `aes_key` = K at all times after a start is accepted.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces the following; reset mid-operation aborts immediately with no `done`:
  - State IDLE.
  - Counter cleared to 0.
  - Outputs `aes_req`, `out_valid`, `upd_start`, `done`, `err`, `busy` = 0.
  - `aes_key`, `aes_pt`, `out_data`, `upd_data`, `v_out` = 0.
  - `reseed_required` = 0.
- Per-block latency with zero-wait AES and consumer: `start`→CHECK 1 cycle, ENC_REQ 1 cycle, then `aes_req` visible.
- `out_valid` rises the cycle after `aes_ack`.
- EMIT→next `aes_req`: 2 cycles.
- `done` rises the cycle after `upd_done`.
- An `aes_ack` outside ENC_WAIT is ignored.
- An `upd_done` outside UPD_WAIT is ignored.
- All outputs are registered.

## Configuration
- `DRBG_GEN_ADDIN_EN` defined:
  - Adds input `addin` (384 bits), latched on accepted start.
  - `upd_data` = latched `addin`.
- `DRBG_GEN_ADDIN_EN` undefined:
  - The `addin` port is absent.
  - `upd_data` is constant 0.

## Test plan
- Basic request:
  - After `reseed_load`, set `v_in`=0x0…05, `num_blocks`=3, `start`, with the AES model returning pt^0xA5…A5.
  - Required: `aes_pt` = 0x…06, 0x…07, 0x…08.
  - Required: three `out_data` blocks equal to those values XOR the pattern.
  - Required: `v_out`=0x…08, then `upd_start` and `done` with `err`=0.
- V wrap:
  - Set `v_in`=all-ones, `num_blocks`=2.
  - Required: `aes_pt` = 0x0 then 0x1.
  - Required: `v_out`=0x1.
- Backpressure and stalls:
  - Hold `out_ready`=0 for 5 cycles and `aes_ack` late by 7 cycles.
  - Required: `out_data`/`aes_pt` stable while stalled.
  - Required: no second `aes_req` before the EMIT handshake.
- Zero and oversize:
  - `num_blocks`=0 → no `aes_req`; `upd_start` then `done`, `err`=0.
  - `num_blocks`=MAX_BLOCKS+1 → `done` with `err`=1; no `aes_req`, no `upd_start`; counter unchanged.
- Reseed limit (with RESEED_LIMIT=2):
  - After `reseed_load`, the 2nd successful request raises `reseed_required`.
  - The 3rd request returns `err`=1.
  - `reseed_load` clears the condition (counter=1).
- Reset mid-operation:
  - Drive `rst_n`=0 in ENC_WAIT.
  - Required: all outputs 0 the next cycle, no `done`.
  - Required: a later `start` operates normally.

Source files
------------

// File: rtl/drbg_generate.sv
// CTR_DRBG generate stage: produces N AES-derived blocks from (Key, V), then hands V to update.
// Define DRBG_GEN_ADDIN_EN to add the 384-bit addin port forwarded as upd_data.
module drbg_generate #(
    parameter int unsigned  MAX_BLOCKS   = 16,
    parameter int unsigned  RESEED_LIMIT = 1024,
    parameter int unsigned  RC_W         = 32,
    localparam int unsigned NW           = $clog2(MAX_BLOCKS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] num_blocks,
    input  logic [255:0]  key_in,
    input  logic [127:0]  v_in,
`ifdef DRBG_GEN_ADDIN_EN
    input  logic [383:0]  addin,
`endif
    input  logic          reseed_load,
    output logic          aes_req,
    output logic [255:0]  aes_key,
    output logic [127:0]  aes_pt,
    input  logic          aes_ack,
    input  logic [127:0]  aes_ct,
    output logic          out_valid,
    output logic [127:0]  out_data,
    input  logic          out_ready,
    output logic          upd_start,
    output logic [383:0]  upd_data,
    output logic [127:0]  v_out,
    input  logic          upd_done,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          reseed_required
);

    typedef enum logic [2:0] {
        StIdle, StCheck, StEncReq, StEncWait, StEmit, StUpd, StUpdWait, StFin
    } state_e;

    state_e          state_q, state_d;
    logic [255:0]    k_q, k_d;
    logic [127:0]    v_q, v_d;
    logic [NW-1:0]   n_q, n_d;
    logic [NW-1:0]   blk_q, blk_d;
    logic [RC_W-1:0] ctr_q, ctr_d;
    logic            aes_req_q, aes_req_d;
    logic            out_valid_q, out_valid_d;
    logic [127:0]    out_data_q, out_data_d;
    logic            upd_start_q, upd_start_d;
    logic [127:0]    v_out_q, v_out_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            rr_q, rr_d;
`ifdef DRBG_GEN_ADDIN_EN
    logic [383:0]    addin_q, addin_d;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        v_d         = v_q;
        n_d         = n_q;
        blk_d       = blk_q;
        ctr_d       = ctr_q;
        aes_req_d   = aes_req_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        v_out_d     = v_out_q;
        err_d       = err_q;
        upd_start_d = 1'b0;
        done_d      = 1'b0;
`ifdef DRBG_GEN_ADDIN_EN
        addin_d     = addin_q;
`endif
        unique case (state_q)
            StIdle: begin
                // reseed_load takes effect before a coincident start is checked
                if (reseed_load) ctr_d = RC_W'(1);
                if (start) begin
                    k_d     = key_in;
                    v_d     = v_in;
                    n_d     = num_blocks;
                    blk_d   = '0;
                    err_d   = 1'b0;
                    state_d = StCheck;
`ifdef DRBG_GEN_ADDIN_EN
                    addin_d = addin;
`endif
                end
            end
            StCheck: begin
                if (rr_q || (n_q > NW'(MAX_BLOCKS))) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else if (n_q == '0) begin
                    state_d = StUpd;
                end else begin
                    state_d = StEncReq;
                end
            end
            StEncReq: begin
                v_d       = v_q + 128'd1;
                aes_req_d = 1'b1;
                state_d   = StEncWait;
            end
            StEncWait: begin
                if (aes_ack) begin
                    aes_req_d   = 1'b0;
                    out_data_d  = aes_ct;
                    out_valid_d = 1'b1;
                    state_d     = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    blk_d       = blk_q + NW'(1);
                    state_d     = (blk_d == n_q) ? StUpd : StEncReq;
                end
            end
            StUpd: begin
                upd_start_d = 1'b1;
                v_out_d     = v_q;
                state_d     = StUpdWait;
            end
            StUpdWait: begin
                if (upd_done) begin
                    done_d  = 1'b1;
                    state_d = StFin;
                end
            end
            StFin: begin
                if (!err_q && (ctr_q != {RC_W{1'b1}})) ctr_d = ctr_q + RC_W'(1);
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        rr_d   = ctr_d > RC_W'(RESEED_LIMIT);
        busy_d = state_d != StIdle;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            v_q         <= '0;
            n_q         <= '0;
            blk_q       <= '0;
            ctr_q       <= '0;
            aes_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            upd_start_q <= 1'b0;
            v_out_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            rr_q        <= 1'b0;
`ifdef DRBG_GEN_ADDIN_EN
            addin_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            v_q         <= v_d;
            n_q         <= n_d;
            blk_q       <= blk_d;
            ctr_q       <= ctr_d;
            aes_req_q   <= aes_req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            upd_start_q <= upd_start_d;
            v_out_q     <= v_out_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            rr_q        <= rr_d;
`ifdef DRBG_GEN_ADDIN_EN
            addin_q     <= addin_d;
`endif
        end
    end

    assign aes_req         = aes_req_q;
    assign aes_key         = k_q;
    assign aes_pt          = v_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign upd_start       = upd_start_q;
    assign v_out           = v_out_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign reseed_required = rr_q;
`ifdef DRBG_GEN_ADDIN_EN
    assign upd_data        = addin_q;
`else
    assign upd_data        = '0;
`endif

endmodule

// File: tb/tb_drbg_generate.sv
// Scoreboard bench for drbg_generate: requests push expected AES plaintexts, blocks, final V
// and err into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_drbg_generate;

    localparam int unsigned  MAXB  = 16;
    localparam int unsigned  LIMIT = 2;
    localparam logic [127:0] PAT   = {16{8'hA5}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [4:0]   num_blocks;
    logic [255:0] key_in;
    logic [127:0] v_in;
    logic         reseed_load;
    logic         aes_req;
    logic [255:0] aes_key;
    logic [127:0] aes_pt;
    logic         aes_ack;
    logic [127:0] aes_ct;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic         upd_start;
    logic [383:0] upd_data;
    logic [127:0] v_out;
    logic         upd_done;
    logic         busy;
    logic         done;
    logic         err;
    logic         reseed_required;
`ifdef DRBG_GEN_ADDIN_EN
    logic [383:0] addin;
`endif

    always #5 clk = ~clk;

    drbg_generate #(
        .MAX_BLOCKS  (MAXB),
        .RESEED_LIMIT(LIMIT),
        .RC_W        (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_blocks     (num_blocks),
        .key_in         (key_in),
        .v_in           (v_in),
`ifdef DRBG_GEN_ADDIN_EN
        .addin          (addin),
`endif
        .reseed_load    (reseed_load),
        .aes_req        (aes_req),
        .aes_key        (aes_key),
        .aes_pt         (aes_pt),
        .aes_ack        (aes_ack),
        .aes_ct         (aes_ct),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .upd_start      (upd_start),
        .upd_data       (upd_data),
        .v_out          (v_out),
        .upd_done       (upd_done),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .reseed_required(reseed_required)
    );

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  m_ctr  = 0;
    bit           noise, stall_mode, aes_hold, upd_real;
    logic [127:0] exp_pt[$];
    logic [255:0] exp_key[$];
    logic [127:0] exp_out[$];
    logic [127:0] exp_vout[$];
    logic [383:0] exp_upd[$];
    logic         exp_err[$];

    task automatic chk(input string name, input logic [383:0] got, input logic [383:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_evt(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand128(), rand128()};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_aes_req"}, aes_req, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_upd_start"}, upd_start, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_aes_key"}, aes_key, '0);
        chk({tag, "_aes_pt"}, aes_pt, '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_upd_data"}, upd_data, '0);
        chk({tag, "_v_out"}, v_out, '0);
        chk({tag, "_reseed_required"}, reseed_required, 1'b0);
    endtask

    // Reference: request i produces plaintext V+i, block (V+i)^PAT, final V+N; counter bumps on success.
    task automatic do_req(input logic [127:0] v, input int n, input bit rl);
        logic [255:0] key;
        logic [383:0] ad;
        logic [127:0] pt;
        bit           got;
        key = rand256();
        ad  = '0;
`ifdef DRBG_GEN_ADDIN_EN
        ad  = {rand256(), rand128()};
`endif
        @(posedge clk); #1;
        key_in      = key;
        v_in        = v;
        num_blocks  = 5'(n);
        start       = 1'b1;
        reseed_load = rl;
`ifdef DRBG_GEN_ADDIN_EN
        addin       = ad;
`endif
        if (rl) m_ctr = 1;
        if (m_ctr > LIMIT || n > int'(MAXB)) begin
            exp_err.push_back(1'b1);
        end else begin
            for (int i = 1; i <= n; i++) begin
                pt = v + 128'(i);
                exp_pt.push_back(pt);
                exp_key.push_back(key);
                exp_out.push_back(pt ^ PAT);
            end
            exp_vout.push_back(v + 128'(n));
            exp_upd.push_back(ad);
            exp_err.push_back(1'b0);
            if (m_ctr != 32'hFFFF_FFFF) m_ctr++;
        end
        got = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (noise) begin
                start       = ($urandom_range(0, 3) == 0);
                reseed_load = ($urandom_range(0, 3) == 0);
                key_in      = rand256();
                v_in        = rand128();
                num_blocks  = 5'($urandom_range(0, 31));
            end else begin
                start       = 1'b0;
                reseed_load = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_evt("done_timeout", "no done within 4000 cycles");
        @(posedge clk); #1;
        start       = 1'b0;
        reseed_load = 1'b0;
        @(negedge clk);
        chk("busy_idle", busy, 1'b0);
        chk("reseed_required", reseed_required, m_ctr > LIMIT);
        chk("pending_expectations",
            exp_pt.size() + exp_out.size() + exp_vout.size() + exp_err.size(), 0);
    endtask

    task automatic reseed_pulse();
        @(posedge clk); #1;
        reseed_load = 1'b1;
        @(posedge clk); #1;
        reseed_load = 1'b0;
        m_ctr = 1;
        @(negedge clk);
        chk("reseed_load_clears", reseed_required, 1'b0);
    endtask

    // AES engine: ct = pt ^ PAT after a random or forced latency; spurious acks while idle.
    initial begin : aes_model
        bit           seen;
        int           cnt;
        logic [127:0] hold;
        seen    = 0;
        cnt     = 0;
        hold    = '0;
        aes_ack = 1'b0;
        aes_ct  = '0;
        forever begin
            @(posedge clk); #1;
            aes_ack = 1'b0;
            if (!aes_req) begin
                seen = 0;
                if (rst_n && $urandom_range(0, 7) == 0) begin
                    aes_ack = 1'b1;
                    aes_ct  = rand128();
                end
            end else begin
                if (!seen) begin
                    seen = 1;
                    cnt  = stall_mode ? 7 : $urandom_range(0, 3);
                    hold = aes_pt;
                end
                if (cnt == 0 && !aes_hold) begin
                    chk("aes_pt_stable", aes_pt, hold);
                    aes_ack = 1'b1;
                    aes_ct  = aes_pt ^ PAT;
                    seen    = 0;
                end else if (cnt > 0) begin
                    cnt--;
                end
            end
        end
    end

    // Update stage: answers upd_start after 0..3 cycles; spurious upd_done while idle.
    initial begin : upd_model
        bit           pend;
        int           cnt;
        logic [127:0] hold;
        pend     = 0;
        cnt      = 0;
        hold     = '0;
        upd_done = 1'b0;
        upd_real = 1'b0;
        forever begin
            @(posedge clk); #1;
            upd_done = 1'b0;
            upd_real = 1'b0;
            if (!busy) pend = 0;
            if (upd_start) begin
                pend = 1;
                cnt  = $urandom_range(0, 3);
                hold = v_out;
            end
            if (pend) begin
                if (cnt == 0) begin
                    chk("v_out_stable", v_out, hold);
                    upd_done = 1'b1;
                    upd_real = 1'b1;
                    pend     = 0;
                end else begin
                    cnt--;
                end
            end else if (rst_n && !busy && $urandom_range(0, 7) == 0) begin
                upd_done = 1'b1;
            end
        end
    end

    // Consumer: random ready, or a 5-cycle hold-off on each new block in stall mode.
    initial begin : consumer
        int stall;
        bit ov_seen;
        stall     = 0;
        ov_seen   = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_mode && out_valid && !ov_seen) stall = 5;
            ov_seen = out_valid;
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = stall_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : monitor
        bit           req_prev, ov_prev, ack_prev, updd_prev, blk_pending;
        logic [127:0] od_hold;
        req_prev    = 0;
        ov_prev     = 0;
        ack_prev    = 0;
        updd_prev   = 0;
        blk_pending = 0;
        od_hold     = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack_prev) chk("out_valid_after_ack", out_valid, 1'b1);
                if (updd_prev) chk("done_after_upd_done", done, 1'b1);
                if (aes_req && !req_prev) begin
                    chk("aes_req_before_handshake", blk_pending, 1'b0);
                    blk_pending = 1;
                    if (exp_pt.size() == 0) begin
                        fail_evt("aes_req", "request with no block expected");
                    end else begin
                        chk("aes_pt", aes_pt, exp_pt.pop_front());
                        chk("aes_key", aes_key, exp_key.pop_front());
                    end
                end
                if (out_valid && !ov_prev) od_hold = out_data;
                if (out_valid && out_ready) begin
                    chk("out_data_stable", out_data, od_hold);
                    blk_pending = 0;
                    if (exp_out.size() == 0) fail_evt("out_data", "block with none expected");
                    else chk("out_data", out_data, exp_out.pop_front());
                end
                if (upd_start) begin
                    if (exp_vout.size() == 0) begin
                        fail_evt("upd_start", "update start with none expected");
                    end else begin
                        chk("v_out", v_out, exp_vout.pop_front());
                        chk("upd_data", upd_data, exp_upd.pop_front());
                    end
                end
                if (done) begin
                    if (exp_err.size() == 0) fail_evt("done", "done with no request pending");
                    else chk("err", err, exp_err.pop_front());
                end
                if (!busy) blk_pending = 0;
            end
            req_prev  = aes_req;
            ov_prev   = out_valid;
            ack_prev  = aes_ack && aes_req;
            updd_prev = upd_done && upd_real;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        bit got;
        rst_n       = 1'b0;
        start       = 1'b0;
        reseed_load = 1'b0;
        key_in      = '0;
        v_in        = '0;
        num_blocks  = '0;
`ifdef DRBG_GEN_ADDIN_EN
        addin       = '0;
`endif
        noise       = 0;
        stall_mode  = 0;
        aes_hold    = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_req(128'h5, 3, 1'b1);
        do_req('1, 2, 1'b1);
        stall_mode = 1;
        do_req(rand128(), 3, 1'b1);
        stall_mode = 0;
        do_req(rand128(), 0, 1'b1);
        do_req(rand128(), MAXB + 1, 1'b0);
        do_req(rand128(), 1, 1'b0);
        do_req(rand128(), 2, 1'b0);
        reseed_pulse();
        do_req(rand128(), 1, 1'b0);

        noise = 1;
        for (int r = 0; r < 30; r++) begin
            logic [127:0] v;
            v = ($urandom_range(0, 3) == 0) ? ('1 - 128'($urandom_range(0, 3))) : rand128();
            do_req(v, $urandom_range(0, 18), $urandom_range(0, 2) == 0);
        end
        noise = 0;

        // Abort a request while it waits on the AES engine.
        @(posedge clk); #1;
        key_in      = rand256();
        v_in        = rand128();
        num_blocks  = 5'd4;
        start       = 1'b1;
        reseed_load = 1'b1;
        aes_hold    = 1;
        exp_pt.push_back(v_in + 128'd1);
        exp_key.push_back(key_in);
        @(posedge clk); #1;
        start       = 1'b0;
        reseed_load = 1'b0;
        got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (aes_req) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_evt("abort_aes_req_timeout", "no aes_req within 50 cycles");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("abort");
        exp_pt.delete();
        exp_key.delete();
        exp_out.delete();
        exp_vout.delete();
        exp_upd.delete();
        exp_err.delete();
        m_ctr    = 0;
        aes_hold = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        do_req(rand128(), 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
